mux4to1_df_continuous_assign: RTL and testbench



---
 rtl/mux4to1_df_continuous_assign.sv | 31 +++
 tb/tb_mux4to1_df_continuous_assign.sv | 93 +++++++++
 2 files changed

// File: rtl/mux4to1_df_continuous_assign.sv
// mux4to1_df_continuous_assign: dataflow 4:1 mux with a registered copy y_q.
// Define MUX4_DF_OUTPUT_REG_EN to drive y from y_q instead of the combinational select.
module mux4to1_df_continuous_assign #(
  parameter int WIDTH = 1
) (
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] y_q
);
  logic [3:0]       sel;
  logic [WIDTH-1:0] y_comb;
  // one-hot decode; X on a select propagates to y_comb unmasked
  assign sel    = {s1 & s0, s1 & ~s0, ~s1 & s0, ~s1 & ~s0};
  assign y_comb = ({WIDTH{sel[0]}} & i0) | ({WIDTH{sel[1]}} & i1) |
                  ({WIDTH{sel[2]}} & i2) | ({WIDTH{sel[3]}} & i3);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) y_q <= '0;
    else        y_q <= y_comb;
`ifdef MUX4_DF_OUTPUT_REG_EN
  assign y = y_q;
`else
  assign y = y_comb;
`endif
endmodule

// File: tb/tb_mux4to1_df_continuous_assign.sv
// tb_mux4to1_df_continuous_assign: directed checks of WIDTH=1 and WIDTH=4 instances.
module tb_mux4to1_df_continuous_assign;
  logic       clk = 0, rst_n = 0, s1 = 0, s0 = 0;
  logic       a0 = 0, a1 = 0, a2 = 0, a3 = 0;
  logic [3:0] b0 = 0, b1 = 0, b2 = 0, b3 = 0;
  logic       y1, q1;
  logic [3:0] y4, q4;
  int         n_assert = 0, n_fail = 0;

  mux4to1_df_continuous_assign #(.WIDTH(1)) u1 (
    .s1(s1), .s0(s0), .i0(a0), .i1(a1), .i2(a2), .i3(a3),
    .y(y1), .clk(clk), .rst_n(rst_n), .y_q(q1));
  mux4to1_df_continuous_assign #(.WIDTH(4)) u4 (
    .s1(s1), .s0(s0), .i0(b0), .i1(b1), .i2(b2), .i3(b3),
    .y(y4), .clk(clk), .rst_n(rst_n), .y_q(q4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // registered build: y shows the selection one edge later
  task automatic chk_y(input string tag, input logic e1, input logic [3:0] e4);
`ifdef MUX4_DF_OUTPUT_REG_EN
    @(posedge clk);
`endif
    #1;
    chk({tag, "_y1"}, {3'b0, y1}, {3'b0, e1});
    chk({tag, "_y4"}, y4, e4);
  endtask

  initial begin
    #1;
    chk("rst_q1", {3'b0, q1}, 4'h0);
    chk("rst_q4", q4, 4'h0);
    a1 = 1; b1 = 4'hA; s0 = 1;
    #1;
`ifdef MUX4_DF_OUTPUT_REG_EN
    chk("rst_y1", {3'b0, y1}, 4'h0);
    chk("rst_y4", y4, 4'h0);
`else
    chk("rst_comb_y1", {3'b0, y1}, 4'h1);
    chk("rst_comb_y4", y4, 4'hA);
`endif
    @(posedge clk); #1;
    chk("rst_hold_q4", q4, 4'h0);
    a0 = 0; a1 = 1; a2 = 0; a3 = 1;
    b0 = 4'h3; b1 = 4'hA; b2 = 4'h5; b3 = 4'hC;
    @(negedge clk) rst_n = 1;
    {s1, s0} = 2'b00; chk_y("sel00", 1'b0, 4'h3);
    {s1, s0} = 2'b01; chk_y("sel01", 1'b1, 4'hA);
    {s1, s0} = 2'b10; chk_y("sel10", 1'b0, 4'h5);
    {s1, s0} = 2'b11; chk_y("sel11", 1'b1, 4'hC);
    {s1, s0} = 2'b10;
    a2 = 1; b2 = 4'hF; chk_y("i2_hi", 1'b1, 4'hF);
    a2 = 0; b2 = 4'h5; chk_y("i2_lo", 1'b0, 4'h5);
    a0 = 1; a1 = 0; a3 = 0; b0 = 4'hF; b1 = 4'hF; b3 = 4'hF;
    chk_y("other_inputs", 1'b0, 4'h5);
    a0 = 0; a1 = 1; a3 = 1; b0 = 4'h3; b1 = 4'hA; b3 = 4'hC;
    @(negedge clk) {s1, s0} = 2'b11;
    #1;
    chk("pre_edge_q1", {3'b0, q1}, 4'h0);
    @(posedge clk); #1;
    chk("load_q1", {3'b0, q1}, 4'h1);
    chk("load_q4", q4, 4'hC);
    @(negedge clk) {s1, s0} = 2'b00;
    #1;
    chk("hold_q4", q4, 4'hC);
    @(posedge clk); #1;
    chk("next_q4", q4, 4'h3);
    @(negedge clk) {s1, s0} = 2'b11;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("async_q1", {3'b0, q1}, 4'h0);
    chk("async_q4", q4, 4'h0);
`ifdef MUX4_DF_OUTPUT_REG_EN
    chk("async_y4", y4, 4'h0);
`else
    chk("async_y4", y4, 4'hC);
`endif
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("reload_q4", q4, 4'hC);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
